fadd_arbiter: RTL
=================

// Module: fadd_arbiter
// PURPOSE
//  Shares one pipelined fadd unit (fixed latency FADD_LAT) between NREQ requesters.
//  - Round-robin arbitration over per-requester valid/ready request channels.
//  - Registers the winning operands into fadd, tracks the owner of each in-flight op.
//  - Returns each sum into a one-entry per-requester result slot, with its own valid/ready response channel.
//  - Sits between the core's FP issue logic and the fadd datapath; fadd itself is instantiated outside this block.
// PARAMETERS
//  NREQ      2  number of requesters, 1..8
//  FADD_LAT  2  fadd latency in clocks, from operands presented on fadd_x1/x2 to fadd_y valid; >=1
// PORTS
//  clk         in   1         clock, all logic on rising edge
//  rst         in   1         synchronous reset, active-high
//  req_valid   in   NREQ      request i valid
//  req_ready   out  NREQ      request i accepted this cycle (combinational)
//  req_x1      in   32*NREQ   operand 1, IEEE754 single; requester i at bits [32i+31:32i]
//  req_x2      in   32*NREQ   operand 2, same packing as req_x1
//  resp_valid  out  NREQ      result slot i holds a sum
//  resp_ready  in   NREQ      requester i takes its result
//  resp_y      out  32*NREQ   sum for requester i, same packing as req_x1
//  fadd_x1     out  32        registered operand 1 to fadd
//  fadd_x2     out  32        registered operand 2 to fadd
//  fadd_y      in   32        fadd result
//  issue_count out  32        only present with FADD_ARB_STATS_EN
// BEHAVIOUR
//  Reset
//  - Synchronous, active-high. Dominates every other event in the same cycle.
//  - Every requester state goes to IDLE; all in-flight ops are discarded.
//  - RR pointer goes to 0; fadd_x1, fadd_x2 and resp_y go to 0.
//  - req_ready and resp_valid are 0 while rst is high.
//  - A result in flight when reset asserts is never delivered.
//  Per-requester FSM, states IDLE / BUSY / DONE
//  - IDLE -> BUSY on grant.
//  - BUSY -> DONE when that requester's result is captured into its slot.
//  - DONE -> IDLE on resp_valid & resp_ready.
//  - Only IDLE requesters are eligible for a grant, so each requester has at most one op outstanding.
//  Arbitration
//  - Eligible(i) = req_valid[i] & state[i]==IDLE.
//  - At most one grant per cycle, to the first eligible i at or after the pointer, modulo NREQ.
//  - req_ready[i] = grant[i]; the handshake completes in the same cycle.
//  - On a grant to k, the pointer becomes (k+1) mod NREQ; with no grant the pointer holds.
//  - No eligible requester: no grant, and fadd_x1/x2 hold their values.
//  Pipeline timing (grant in cycle t)
//  - fadd_x1/x2 are loaded at the end of t and valid in t+1.
//  - fadd_y is sampled in cycle t+1+FADD_LAT and written to resp_y[k] at the end of that cycle.
//  - resp_valid[k] rises in t+2+FADD_LAT: total latency FADD_LAT+2 cycles from handshake to resp_valid.
//  - Tracking is a FADD_LAT+1 deep shift register of {valid, id}; back-to-back grants fill one stage per cycle.
//  - Aggregate throughput: 1 op/cycle.
//  - Per-requester throughput: 1 op per FADD_LAT+3 cycles. New req_ready is possible the cycle after the resp handshake.
//  Response channel
//  - resp_y[i] is stable while resp_valid[i] is high.
//  - The slot is never overwritten, because BUSY implies the slot is empty, so no result is lost.
//  - A requester holding resp_ready low stalls only itself; other requesters keep issuing.
//  - Simultaneous resp handshake and req_valid on the same requester: the request is not granted that cycle. It is eligible next cycle.
//  - Simultaneous result capture for i and grant to j!=i are independent.
//  Arithmetic
//  - No FP processing here; operands and results pass through bit-exact.
// CONFIGURATION
//  FADD_ARB_STATS_EN defined:
//  - Adds output issue_count[31:0], reset to 0, +1 per grant.
//  - Wraps 0xFFFFFFFF -> 0.
//  FADD_ARB_STATS_EN undefined:
//  - The port and the counter do not exist; all other behaviour is identical.
// TESTING
//  Bench: behavioural fadd model with FADD_LAT-cycle delay; reference sums via $bitstoshortreal.
//  1. Single op: req0 issues x1=0x3F800000, x2=0x40000000 -> resp_valid[0] 4 cycles later (FADD_LAT=2), resp_y[0]=0x40400000.
//  2. Contention: req0 and req1 both valid from reset release.
//     - Grants go req0 then req1 in consecutive cycles.
//     - req1 sum 0x40A00000+0xC0400000 -> 0x40000000, one cycle after req0's result.
//  3. Fairness: NREQ=4, all valid continuously, resp_ready=1 -> grants rotate 0,1,2,3,0; no requester starved.
//  4. Backpressure: resp_ready[1]=0 for 20 cycles.
//     - resp_y[1] holds, req_ready[1]=0 throughout.
//     - req0 keeps completing one op per 5 cycles.
//  5. Reset mid-flight: assert rst 1 cycle after a grant.
//     - No resp_valid afterwards; all outputs 0.
//     - A new op after release returns its correct sum.
//  6. Stats (FADD_ARB_STATS_EN): 100 random ops -> issue_count=100; all sums match the reference bit-exact.

Source files
------------

// File: rtl/fadd_arbiter.sv
// fadd_arbiter: round-robin sharing of one pipelined fadd among NREQ requesters.
// Optional grant counter on issue_count when FADD_ARB_STATS_EN is defined.
module fadd_arbiter #(
  parameter int NREQ     = 2,
  parameter int FADD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_x1,
  input  logic [32*NREQ-1:0] req_x2,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [32*NREQ-1:0] resp_y,
  output logic [31:0]       fadd_x1,
  output logic [31:0]       fadd_x2,
  input  logic [31:0]       fadd_y
`ifdef FADD_ARB_STATS_EN
  ,
  output logic [31:0]       issue_count
`endif
);

  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = FADD_LAT + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } st_t;

  st_t           state_q [NREQ];
  st_t           state_d [NREQ];
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [NREQ-1:0] grant;
  logic          gnt_any;
  logic [IW-1:0] gnt_id;
  logic          trk_v  [DEPTH];
  logic [IW-1:0] trk_id [DEPTH];
  logic          cap_v;
  logic [IW-1:0] cap_id;

  // last tracking stage lines up with fadd_y for that op
  assign cap_v  = trk_v[DEPTH-1];
  assign cap_id = trk_id[DEPTH-1];

  always_comb begin : arb
    logic [IW-1:0] c;
    grant   = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    c       = '0;
    for (int o = 0; o < NREQ; o++) begin
      c = IW'((int'(ptr_q) + o) % NREQ);
      if (!gnt_any && req_valid[c] &&
          state_q[c] == IDLE) begin
        gnt_any = 1'b1;
        gnt_id  = c;
      end
    end
    if (rst) gnt_any = 1'b0;
    if (gnt_any) grant[gnt_id] = 1'b1;
  end

  assign req_ready = grant;

  always_comb begin : ptr_next
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (gnt_id == IW'(NREQ - 1))
        ptr_d = '0;
      else
        ptr_d = gnt_id + 1'b1;
    end
  end

  always_comb begin : fsm
    for (int i = 0; i < NREQ; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        IDLE: if (grant[i]) state_d[i] = BUSY;
        BUSY: if (cap_v && cap_id == IW'(i))
                state_d[i] = DONE;
        DONE: if (resp_ready[i]) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin : rv
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++)
      resp_valid[i] = !rst && state_q[i] == DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++)
        state_q[i] <= IDLE;
      for (int d = 0; d < DEPTH; d++) begin
        trk_v[d]  <= 1'b0;
        trk_id[d] <= '0;
      end
      ptr_q   <= '0;
      fadd_x1 <= '0;
      fadd_x2 <= '0;
      resp_y  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        state_q[i] <= state_d[i];
      ptr_q <= ptr_d;
      if (gnt_any) begin
        fadd_x1 <= req_x1[{gnt_id, 5'b0} +: 32];
        fadd_x2 <= req_x2[{gnt_id, 5'b0} +: 32];
      end
      trk_v[0]  <= gnt_any;
      trk_id[0] <= gnt_id;
      for (int d = 1; d < DEPTH; d++) begin
        trk_v[d]  <= trk_v[d-1];
        trk_id[d] <= trk_id[d-1];
      end
      if (cap_v)
        resp_y[{cap_id, 5'b0} +: 32] <= fadd_y;
    end
  end

`ifdef FADD_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      issue_count <= '0;
    else if (gnt_any)
      issue_count <= issue_count + 32'd1;
  end
`endif

endmodule
